pong_engine: RTL and testbench

Parametrised single-clock Pong game core. It replaces the separate divider, player, computer and ball blocks with one engine.
- Internal tick divider, game FSM, two paddles, ball, and per-side score counters with a win threshold.
- Each right paddle is selectable as human or computer at run time.
- Drives packed {x,y} positions to the VGA draw logic and scores to the display counter.

---
 rtl/pong_engine.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_pong_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// Single-clock Pong engine: tick divider, game FSM, two paddles, ball and per-side scores.
// Latency: game state advances on the tick cycle; registered outputs show it the following cycle.
// Backpressure: none; controls are levels sampled on ticks, outputs are free-running.
module pong_engine #(
    parameter int COORD_W     = 12,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int PAD_MARGIN  = 16,
    parameter int BALL_SZ     = 8,
    parameter int PADDLE_STEP = 4,
    parameter int AI_STEP     = 2,
    parameter int BALL_STEP   = 2,
    parameter int TICK_DIV    = 1666667,
    parameter int SERVE_TICKS = 60,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9
) (
    input  logic                 CLK_100MHz,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 l_up,
    input  logic                 l_down,
    input  logic                 r_up,
    input  logic                 r_down,
    output logic [2*COORD_W-1:0] LPosition,
    output logic [2*COORD_W-1:0] RPosition,
    output logic [2*COORD_W-1:0] BPosition,
    output logic [SCORE_W-1:0]   LScore,
    output logic [SCORE_W-1:0]   RScore,
    output logic                 point_l,
    output logic                 point_r,
    output logic                 game_over,
    output logic                 winner,
    output logic                 tick,
    output logic [1:0]           state
);
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pos_t;

    // Two spare bits so sums like nx+BALL_SZ and negative steps never wrap.
    typedef logic signed [COORD_W+1:0] sc_t;

    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} st_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SERVE_TICKS > 0) ? $clog2(SERVE_TICKS + 1) : 1;

    localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

    localparam sc_t K_ZERO  = '0;
    localparam sc_t K_LX    = sc_t'(PAD_MARGIN);
    localparam sc_t K_RX    = sc_t'(SCREEN_W - PAD_MARGIN - PADDLE_W);
    localparam sc_t K_LFACE = sc_t'(PAD_MARGIN + PADDLE_W);
    localparam sc_t K_RSTOP = sc_t'(SCREEN_W - PAD_MARGIN - PADDLE_W - BALL_SZ);
    localparam sc_t K_PYMAX = sc_t'(SCREEN_H - PADDLE_H);
    localparam sc_t K_BXMAX = sc_t'(SCREEN_W - BALL_SZ);
    localparam sc_t K_BYMAX = sc_t'(SCREEN_H - BALL_SZ);
    localparam sc_t K_BX0   = sc_t'((SCREEN_W - BALL_SZ) / 2);
    localparam sc_t K_BY0   = sc_t'((SCREEN_H - BALL_SZ) / 2);
    localparam sc_t K_PY0   = sc_t'((SCREEN_H - PADDLE_H) / 2);
    localparam sc_t K_BSZ   = sc_t'(BALL_SZ);
    localparam sc_t K_PH    = sc_t'(PADDLE_H);
    localparam sc_t K_HB    = sc_t'(BALL_SZ / 2);
    localparam sc_t K_HP    = sc_t'(PADDLE_H / 2);
    localparam sc_t K_PST   = sc_t'(PADDLE_STEP);
    localparam sc_t K_AST   = sc_t'(AI_STEP);
    localparam sc_t K_BST   = sc_t'(BALL_STEP);

    function automatic sc_t ext(input logic [COORD_W-1:0] v);
        return sc_t'({2'b00, v});
    endfunction

    // One paddle move, saturated to the playfield.
    function automatic logic [COORD_W-1:0] step_pad(input logic [COORD_W-1:0] y,
                                                    input logic up, input logic dn,
                                                    input sc_t stp);
        sc_t t;
        t = ext(y);
        if (up && !dn) begin
            t = t - stp;
            if (t < K_ZERO) t = K_ZERO;
        end else if (dn && !up) begin
            t = t + stp;
            if (t > K_PYMAX) t = K_PYMAX;
        end
        return t[COORD_W-1:0];
    endfunction

    logic [TW-1:0]      tcnt;
    st_t                st_q, st_d;
    logic [SW-1:0]      srv_q, srv_d;
    logic [COORD_W-1:0] ly_q, ly_d, ry_q, ry_d, bx_q, bx_d, by_q, by_d;
    logic               vx_q, vx_d, vy_q, vy_d;   // 1 = positive direction
    logic [SCORE_W-1:0] ls_q, ls_d, rs_q, rs_d;
    logic               win_q, win_d, pl_q, pl_d, pr_q, pr_d;
    sc_t                nx, ny, d;
    logic               ov_l, ov_r, hit_l, hit_r, miss_l, miss_r, ai_up, ai_dn;

    always_ff @(posedge CLK_100MHz or negedge Reset) begin
        if (!Reset)            tcnt <= '0;
        else if (tcnt == TMAX) tcnt <= '0;
        else                   tcnt <= tcnt + TW'(1);
    end

    assign tick = (tcnt == TMAX);

    // Ball kinematics and computer-paddle decision from the current registers.
    always_comb begin
        nx     = vx_q ? ext(bx_q) + K_BST : ext(bx_q) - K_BST;
        ny     = vy_q ? ext(by_q) + K_BST : ext(by_q) - K_BST;
        ov_l   = (ny + K_BSZ > ext(ly_q)) && (ny < ext(ly_q) + K_PH);
        ov_r   = (ny + K_BSZ > ext(ry_q)) && (ny < ext(ry_q) + K_PH);
        // The "before the face" term keeps a ball that already slipped past a paddle from bouncing.
        hit_l  = !vx_q && (ext(bx_q) >= K_LFACE) && (nx <= K_LFACE) && ov_l;
        hit_r  = vx_q && (ext(bx_q) + K_BSZ <= K_RX) && (nx + K_BSZ >= K_RX) && ov_r;
        miss_l = !vx_q && (nx <= K_ZERO) && !hit_l;
        miss_r = vx_q && (nx >= K_BXMAX) && !hit_r;
        d      = (ext(by_q) + K_HB) - (ext(ry_q) + K_HP);
        ai_dn  = d > K_AST;
        ai_up  = d < -K_AST;
    end

    always_comb begin
        st_d  = st_q;
        srv_d = srv_q;
        ly_d  = ly_q;
        ry_d  = ry_q;
        bx_d  = bx_q;
        by_d  = by_q;
        vx_d  = vx_q;
        vy_d  = vy_q;
        ls_d  = ls_q;
        rs_d  = rs_q;
        win_d = win_q;
        pl_d  = 1'b0;
        pr_d  = 1'b0;

        if (st_q != OVER) begin
            ly_d = step_pad(ly_q, l_up, l_down, K_PST);
            ry_d = mode ? step_pad(ry_q, r_up, r_down, K_PST)
                        : step_pad(ry_q, ai_up, ai_dn, K_AST);
        end

        case (st_q)
            IDLE: begin
                bx_d = K_BX0[COORD_W-1:0];
                by_d = K_BY0[COORD_W-1:0];
                if (start) begin
                    ls_d  = '0;
                    rs_d  = '0;
                    srv_d = SW'(SERVE_TICKS);
                    st_d  = SERVE;
                end
            end
            SERVE: begin
                bx_d = K_BX0[COORD_W-1:0];
                by_d = K_BY0[COORD_W-1:0];
                // Loaded with SERVE_TICKS on entry; leaving on the tick that reaches 0.
                if (srv_q <= SW'(1)) begin
                    srv_d = '0;
                    st_d  = PLAY;
                end else begin
                    srv_d = srv_q - SW'(1);
                end
            end
            PLAY: begin
                if (ny <= K_ZERO) begin
                    by_d = '0;
                    vy_d = 1'b1;
                end else if (ny >= K_BYMAX) begin
                    by_d = K_BYMAX[COORD_W-1:0];
                    vy_d = 1'b0;
                end else begin
                    by_d = ny[COORD_W-1:0];
                end

                if (hit_l) begin
                    bx_d = K_LFACE[COORD_W-1:0];
                    vx_d = 1'b1;
                end else if (hit_r) begin
                    bx_d = K_RSTOP[COORD_W-1:0];
                    vx_d = 1'b0;
                end else if (miss_l) begin
                    pr_d = 1'b1;
                    if (rs_q < SCORE_W'(WIN_SCORE)) rs_d = rs_q + SCORE_W'(1);
                    if (rs_q >= SCORE_W'(WIN_SCORE - 1)) begin
                        st_d  = OVER;
                        win_d = 1'b1;
                        bx_d  = '0;
                    end else begin
                        st_d  = SERVE;
                        srv_d = SW'(SERVE_TICKS);
                        bx_d  = K_BX0[COORD_W-1:0];
                        by_d  = K_BY0[COORD_W-1:0];
                        vx_d  = 1'b0;
                    end
                end else if (miss_r) begin
                    pl_d = 1'b1;
                    if (ls_q < SCORE_W'(WIN_SCORE)) ls_d = ls_q + SCORE_W'(1);
                    if (ls_q >= SCORE_W'(WIN_SCORE - 1)) begin
                        st_d  = OVER;
                        win_d = 1'b0;
                        bx_d  = K_BXMAX[COORD_W-1:0];
                    end else begin
                        st_d  = SERVE;
                        srv_d = SW'(SERVE_TICKS);
                        bx_d  = K_BX0[COORD_W-1:0];
                        by_d  = K_BY0[COORD_W-1:0];
                        vx_d  = 1'b1;
                    end
                end else begin
                    bx_d = nx[COORD_W-1:0];
                end
            end
            OVER: begin
                if (start) begin
                    ls_d  = '0;
                    rs_d  = '0;
                    srv_d = SW'(SERVE_TICKS);
                    bx_d  = K_BX0[COORD_W-1:0];
                    by_d  = K_BY0[COORD_W-1:0];
                    st_d  = SERVE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_100MHz or negedge Reset) begin
        if (!Reset) begin
            st_q  <= IDLE;
            srv_q <= '0;
            ly_q  <= K_PY0[COORD_W-1:0];
            ry_q  <= K_PY0[COORD_W-1:0];
            bx_q  <= K_BX0[COORD_W-1:0];
            by_q  <= K_BY0[COORD_W-1:0];
            vx_q  <= 1'b1;
            vy_q  <= 1'b1;
            ls_q  <= '0;
            rs_q  <= '0;
            win_q <= 1'b0;
            pl_q  <= 1'b0;
            pr_q  <= 1'b0;
        end else begin
            // Point pulses last exactly the one cycle after the scoring tick.
            pl_q <= tick & pl_d;
            pr_q <= tick & pr_d;
            if (tick) begin
                st_q  <= st_d;
                srv_q <= srv_d;
                ly_q  <= ly_d;
                ry_q  <= ry_d;
                bx_q  <= bx_d;
                by_q  <= by_d;
                vx_q  <= vx_d;
                vy_q  <= vy_d;
                ls_q  <= ls_d;
                rs_q  <= rs_d;
                win_q <= win_d;
            end
        end
    end

    pos_t lpos, rpos, bpos;
    assign lpos.x = K_LX[COORD_W-1:0];
    assign lpos.y = ly_q;
    assign rpos.x = K_RX[COORD_W-1:0];
    assign rpos.y = ry_q;
    assign bpos.x = bx_q;
    assign bpos.y = by_q;

    assign LPosition = lpos;
    assign RPosition = rpos;
    assign BPosition = bpos;
    assign LScore    = ls_q;
    assign RScore    = rs_q;
    assign point_l   = pl_q;
    assign point_r   = pr_q;
    assign game_over = (st_q == OVER);
    assign winner    = win_q;
    assign state     = st_q;
endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine with a fast tick (TICK_DIV=4), short serve and a 2-point game.
// Latency: checks are taken 1 time unit after the tick edge, when registered outputs have settled.
// Backpressure: none; every wait for a tick is bounded and an expired bound counts as a failure.
module tb_pong_engine;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, mode, l_up, l_down, r_up, r_down;
    logic [2*CW-1:0] LPosition, RPosition, BPosition;
    logic [3:0]    LScore, RScore;
    logic          point_l, point_r, game_over, winner, tick;
    logic [1:0]    state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pong_engine #(
        .TICK_DIV    (4),
        .SERVE_TICKS (2),
        .WIN_SCORE   (2)
    ) dut (
        .CLK_100MHz (clk),
        .Reset      (rst_n),
        .start      (start),
        .mode       (mode),
        .l_up       (l_up),
        .l_down     (l_down),
        .r_up       (r_up),
        .r_down     (r_down),
        .LPosition  (LPosition),
        .RPosition  (RPosition),
        .BPosition  (BPosition),
        .LScore     (LScore),
        .RScore     (RScore),
        .point_l    (point_l),
        .point_r    (point_r),
        .game_over  (game_over),
        .winner     (winner),
        .tick       (tick),
        .state      (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkpos(input string tag, input logic [2*CW-1:0] obs, input int ex, input int ey);
        logic [CW-1:0] xx, yy;
        xx = CW'(ex);
        yy = CW'(ey);
        tests++;
        assert (obs === {xx, yy}) else begin
            fails++;
            $error("FAIL %s: observed {%0d,%0d}, expected {%0d,%0d}",
                   tag, obs[2*CW-1:CW], obs[CW-1:0], ex, ey);
        end
    endtask

    // Advance n game ticks; returns 1 time unit after each tick's updating edge.
    task automatic tk(input int n);
        int c;
        for (int i = 0; i < n; i++) begin
            c = 0;
            @(negedge clk);
            while (tick !== 1'b1 && c < 8) begin
                @(negedge clk);
                c++;
            end
            if (tick !== 1'b1) begin
                tests++;
                fails++;
                $error("FAIL tick_timeout: observed tick=%b, expected tick=1", tick);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int   nhi, first, dbl;
        logic prev;

        rst_n = 1'b0; start = 1'b0; mode = 1'b1;
        l_up = 1'b0; l_down = 1'b0; r_up = 1'b0; r_down = 1'b0;

        // 1. reset values, tick cadence
        #12;
        chk("rst_tick", 32'(tick), 0);
        chk("rst_state", 32'(state), 0);
        #10 rst_n = 1'b1;
        nhi = 0; first = -1; dbl = 0; prev = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (tick === 1'b1) begin
                nhi++;
                if (first < 0) first = n;
                if (prev) dbl++;
            end
            prev = tick;
        end
        chk("tick_count", 32'(nhi), 5);
        chk("tick_first", 32'(first), 3);
        chk("tick_width", 32'(dbl), 0);
        chk("idle_state", 32'(state), 0);
        chkpos("idle_L", LPosition, 16, 208);
        chkpos("idle_R", RPosition, 616, 208);
        chkpos("idle_B", BPosition, 316, 236);
        chk("idle_LScore", 32'(LScore), 0);
        chk("idle_RScore", 32'(RScore), 0);
        chk("idle_game_over", 32'(game_over), 0);
        chk("idle_winner", 32'(winner), 0);
        chk("idle_point_l", 32'(point_l), 0);
        chk("idle_point_r", 32'(point_r), 0);

        // 2. human left paddle, saturation and both-pressed hold
        l_up = 1'b1;
        tk(1);  chkpos("lup_1", LPosition, 16, 204);
        tk(51); chkpos("lup_52", LPosition, 16, 0);
        tk(2);  chkpos("lup_sat", LPosition, 16, 0);
        l_up = 1'b0; l_down = 1'b1;
        tk(2);  chkpos("ldown_2", LPosition, 16, 8);
        l_up = 1'b1;
        tk(2);  chkpos("lboth_hold", LPosition, 16, 8);
        l_down = 1'b0;
        tk(2);  chkpos("lup_park", LPosition, 16, 0);
        l_up = 1'b0;

        // 3. start, serve, play and bottom wall; right paddle driven down to meet the ball
        start = 1'b1; r_down = 1'b1;
        tk(1);  chk("start_state", 32'(state), 1);
                chk("start_RScore", 32'(RScore), 0);
        start = 1'b0;
        tk(1);  chk("serve_state", 32'(state), 1);
                chkpos("serve_B", BPosition, 316, 236);
        tk(1);  chk("play_state", 32'(state), 2);
                chkpos("play_B0", BPosition, 316, 236);
        tk(1);  chkpos("play_B1", BPosition, 318, 238);
        tk(117); chkpos("bottom_wall", BPosition, 552, 472);
        tk(1);  chkpos("bottom_vy_neg", BPosition, 554, 470);
        tk(27); chkpos("right_hit", BPosition, 608, 416);
                chkpos("right_pad", RPosition, 616, 416);
        tk(1);  chkpos("right_vx_neg", BPosition, 606, 414);

        // 4. top wall, ball slips past the parked left paddle, right side scores
        tk(207); chkpos("top_wall", BPosition, 192, 0);
        tk(1);   chkpos("top_vy_pos", BPosition, 190, 2);
        tk(83);  chkpos("left_face", BPosition, 24, 168);
        tk(1);   chkpos("left_pass", BPosition, 22, 170);
        tk(10);  chkpos("left_edge", BPosition, 2, 190);
        tk(1);   chk("miss1_state", 32'(state), 1);
                 chk("miss1_RScore", 32'(RScore), 1);
                 chk("miss1_LScore", 32'(LScore), 0);
                 chk("miss1_point_r", 32'(point_r), 1);
                 chk("miss1_point_l", 32'(point_l), 0);
                 chkpos("miss1_B", BPosition, 316, 236);
        @(posedge clk); #1;
        chk("miss1_point_r_drop", 32'(point_r), 0);
        tk(2);   chk("reserve_state", 32'(state), 2);
        tk(1);   chkpos("serve_left", BPosition, 314, 238);

        // 5. second right point ends the game; restart
        tk(157); chk("over_state", 32'(state), 3);
                 chk("over_game_over", 32'(game_over), 1);
                 chk("over_winner", 32'(winner), 1);
                 chk("over_RScore", 32'(RScore), 2);
                 chk("over_point_r", 32'(point_r), 1);
                 chkpos("over_B", BPosition, 0, 392);
        l_down = 1'b1;
        tk(1);   chkpos("over_L_frozen", LPosition, 16, 0);
                 chkpos("over_B_frozen", BPosition, 0, 392);
                 chk("over_hold_state", 32'(state), 3);
        l_down = 1'b0; mode = 1'b0; r_down = 1'b0; start = 1'b1;
        tk(1);   chk("restart_state", 32'(state), 1);
                 chk("restart_RScore", 32'(RScore), 0);
                 chk("restart_game_over", 32'(game_over), 0);
                 chkpos("restart_R", RPosition, 616, 416);
        start = 1'b0;

        // 6. computer right paddle tracking, deadband, then asynchronous reset
        tk(1);   chkpos("ai_s1", RPosition, 616, 414);
        tk(1);   chkpos("ai_s2", RPosition, 616, 412);
                 chk("ai_play_state", 32'(state), 2);
        tk(1);   chkpos("ai_p1", RPosition, 616, 410);
                 chkpos("ai_p1_B", BPosition, 314, 234);
        tk(117); chkpos("ai_top_B", BPosition, 80, 0);
                 chkpos("ai_top_R", RPosition, 616, 176);
        tk(28);  chkpos("left_hit_B", BPosition, 24, 56);
                 chkpos("left_hit_R", RPosition, 616, 120);
        tk(24);  chkpos("ai_meet_R", RPosition, 616, 74);
                 chkpos("ai_meet_B", BPosition, 72, 104);
        tk(1);   chkpos("ai_deadband", RPosition, 616, 74);
        tk(1);   chkpos("ai_follow_down", RPosition, 616, 76);
                 chkpos("ai_follow_B", BPosition, 76, 108);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 0);
        chkpos("arst_L", LPosition, 16, 208);
        chkpos("arst_R", RPosition, 616, 208);
        chkpos("arst_B", BPosition, 316, 236);
        chk("arst_scores", 32'({LScore, RScore}), 0);
        chk("arst_winner", 32'(winner), 0);
        chk("arst_game_over", 32'(game_over), 0);
        chk("arst_tick", 32'(tick), 0);
        chk("arst_points", 32'({point_l, point_r}), 0);
        #10 rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
